// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, lane limit and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int LANE_MAX = 16;

    localparam byte_t SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_byte.sv
// Single-byte AES substitution: forward or inverse S-box chosen by inv.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);

    // Table lookup, table picked by the per-word mode bit
    always_comb begin
        y = 8'h00;
        if (inv) begin
            y = SBOX_INV[x];
        end else begin
            y = SBOX_FWD[x];
        end
    end

endmodule

// File: rtl/sbox_sub_bytes_pipe.sv
// Two-stage valid/ready SubBytes/InvSubBytes engine: S1 captures the word, S2 holds the
// substituted bytes. The mode bit travels with each word so modes can change every cycle.
module sbox_sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data,
    output logic               busy,
    output logic [CNT_W-1:0]   done_cnt
);

    logic               s1_valid_r;
    logic               s1_inv_r;
    logic [8*LANES-1:0] s1_data_r;
    logic               s2_valid_r;
    logic               s2_inv_r;
    logic [8*LANES-1:0] s2_data_r;
    logic               busy_r;
    logic [CNT_W-1:0]   done_cnt_r;

    logic               s1_adv_s;
    logic               s2_adv_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               deliver_s;
    logic               s1_valid_nxt_s;
    logic               s2_valid_nxt_s;
    logic [8*LANES-1:0] sub_data_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_byte u_sbox (
            .x   (s1_data_r[8*g +: 8]),
            .inv (s1_inv_r),
            .y   (sub_data_s[8*g +: 8])
        );
    end

    // Handshake and next-state valid bits; flush wins over everything else
    always_comb begin
        s2_adv_s       = !s2_valid_r || out_ready;
        s1_adv_s       = s1_valid_r && s2_adv_s;
        in_ready_s     = 1'b0;
        s1_valid_nxt_s = s1_valid_r;
        s2_valid_nxt_s = s2_valid_r;

        if (!rst_n) begin
            in_ready_s = 1'b1;
        end else if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !s1_valid_r || s1_adv_s;
        end

        accept_s  = in_valid && in_ready_s;
        deliver_s = s2_valid_r && out_ready;

        if (flush) begin
            s1_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            s1_valid_nxt_s = 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_nxt_s = 1'b0;
        end else begin
            s1_valid_nxt_s = s1_valid_r;
        end

        if (flush) begin
            s2_valid_nxt_s = 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_nxt_s = s1_valid_r;
        end else begin
            s2_valid_nxt_s = s2_valid_r;
        end
    end

    // Stage registers; data only moves on load so a stalled output stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_inv_r   <= 1'b0;
            s1_data_r  <= '0;
            s2_valid_r <= 1'b0;
            s2_inv_r   <= 1'b0;
            s2_data_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_nxt_s;
            s2_valid_r <= s2_valid_nxt_s;
            busy_r     <= s1_valid_nxt_s || s2_valid_nxt_s;
            if (accept_s) begin
                s1_data_r <= in_data;
                s1_inv_r  <= in_inv;
            end
            if (s1_adv_s && !flush) begin
                s2_data_r <= sub_data_s;
                s2_inv_r  <= s1_inv_r;
            end
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= '0;
        end else if (deliver_s) begin
            done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out_inv   = s2_inv_r;
    assign out_data  = s2_data_r;
    assign busy      = busy_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_sbox_sub_bytes_pipe.sv
// Directed bench with a scoreboard; reference S-box is derived from GF(2^8) arithmetic.
module tb_sbox_sub_bytes_pipe;

    localparam int LANES = 16;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic         inv;
        logic [127:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [8*LANES-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_inv;
    logic [8*LANES-1:0] out_data;
    logic               busy;
    logic [CNT_W-1:0]   done_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_deliv = 0;
    int   exp_done = 0;
    exp_t sb[$];
    exp_t e_mon;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    sbox_sub_bytes_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_data  (out_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic exp_t model(input logic [127:0] d, input logic inv);
        exp_t r;
        r.inv  = inv;
        r.data = '0;
        for (int i = 0; i < LANES; i++) begin
            r.data[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'(base + i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic inv, output int waited);
        logic acc;
        acc      = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (!acc && waited < 30) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        step();
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    // Scoreboard: compare each delivered word, then record each accepted word
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_done = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'd1, 128'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("out_data", out_data, e_mon.data);
                    chk("out_inv", 128'(out_inv), 128'(e_mon.inv));
                    exp_done = (exp_done + 1) % (1 << CNT_W);
                    n_deliv++;
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(model(in_data, in_inv));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   ginv;
        logic [7:0]   b;
        logic [127:0] vec;
        exp_t         ea;
        int           w;
        int           base;

        for (int x = 0; x < 256; x++) begin
            ginv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) ginv = 8'(y);
            end
            b = ginv;
            fwd_t[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
        in_data = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_inv", 128'(out_inv), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done_cnt", 128'(done_cnt), 128'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Forward known-answer and two-register latency
        in_data = {96'h0123456789abcdeffedcba98, 32'h52195300};
        in_inv = 1'b0; in_valid = 1'b1;
        #1 chk("fwd_in_ready", 128'(in_ready), 128'd1);
        step(); in_valid = 1'b0;
        chk("fwd_lat1_valid", 128'(out_valid), 128'd0);
        step();
        chk("fwd_lat2_valid", 128'(out_valid), 128'd1);
        chk("fwd_kat", 128'(out_data[31:0]), 128'(32'h00d4ed63));
        chk("fwd_kat_inv", 128'(out_inv), 128'd0);

        // Inverse known-answer
        in_data = {96'h00112233445566778899aabb, 32'hffed6300};
        in_inv = 1'b1; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        step();
        chk("inv_kat", 128'(out_data[31:0]), 128'(32'h7d530052));
        chk("inv_kat_inv", 128'(out_inv), 128'd1);
        drain();

        // Exhaustive sweep, mode alternating every word, then inverse of S(x)
        base = n_deliv;
        for (int k = 0; k < 16; k++) begin
            send(ramp(16 * k), 1'b0, w);
            chk("alt_rate_fwd", 128'(w), 128'd1);
            send(ramp(16 * k), 1'b1, w);
            chk("alt_rate_inv", 128'(w), 128'd1);
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < LANES; i++) vec[8*i +: 8] = fwd_t[16 * k + i];
            send(vec, 1'b1, w);
            chk("roundtrip_rate", 128'(w), 128'd1);
        end
        step(); step();
        chk("stream_deliv", 128'(n_deliv - base), 128'd48);
        drain();

        // Backpressure: two words buffered, five-cycle stall, then release
        base = n_deliv;
        out_ready = 1'b0;
        send(ramp(8'h40), 1'b0, w);
        send(ramp(8'h90), 1'b1, w);
        ea = model(ramp(8'h40), 1'b0);
        in_valid = 1'b1; in_data = ramp(8'hc0); in_inv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready", 128'(in_ready), 128'd0);
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_out_data", out_data, ea.data);
            chk("stall_out_inv", 128'(out_inv), 128'(ea.inv));
            step();
        end
        out_ready = 1'b1;
        send(ramp(8'hc0), 1'b0, w);
        send(ramp(8'h11), 1'b1, w);
        send(ramp(8'h77), 1'b0, w);
        drain();
        chk("bp_deliv", 128'(n_deliv - base), 128'd5);
        chk("bp_done_cnt", 128'(done_cnt), 128'(exp_done));

        // Flush with both stages full; word presented during flush is dropped
        base = n_deliv;
        out_ready = 1'b0;
        send(ramp(8'h21), 1'b0, w);
        send(ramp(8'h31), 1'b1, w);
        chk("pre_flush_busy", 128'(busy), 128'd1);
        in_valid = 1'b1; in_data = ramp(8'h51); in_inv = 1'b0;
        flush = 1'b1;
        #1 chk("flush_in_ready", 128'(in_ready), 128'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_busy", 128'(busy), 128'd0);
        chk("flush_done_cnt", 128'(done_cnt), 128'(exp_done));
        out_ready = 1'b1;
        send(ramp(8'h61), 1'b1, w);
        drain();
        chk("post_flush_deliv", 128'(n_deliv - base), 128'd1);

        // Asynchronous reset with words in flight
        out_ready = 1'b0;
        send(ramp(8'h03), 1'b0, w);
        send(ramp(8'h13), 1'b1, w);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_out_data", out_data, 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_done_cnt", 128'(done_cnt), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        base = n_deliv;
        send(ramp(8'ha5), 1'b1, w);
        drain();
        chk("post_rst_deliv", 128'(n_deliv - base), 128'd1);

        // Counter wrap: 16 words after reset bring a 4-bit count back to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) send(ramp(k * 7), k[0], w);
        drain();
        chk("cnt_15", 128'(done_cnt), 128'd15);
        send(ramp(8'h2b), 1'b0, w);
        drain();
        chk("cnt_wrap_0", 128'(done_cnt), 128'd0);
        send(ramp(8'h3c), 1'b1, w);
        drain();
        chk("cnt_wrap_1", 128'(done_cnt), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
